// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch (ifu) and
// load/store (lsu) paths through a 3-state FSM with a req/ack handshake.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin between ifu and lsu on contention
//   undefined -> fixed priority, lsu always beats ifu
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   if_req/if_addr              fetch request in
//   if_gnt/if_rvalid/if_rdata   fetch accept, completion, data out
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_wstrb           load/store request in
//   ls_gnt/ls_rvalid/ls_rdata   load/store accept, completion, data out
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb         memory request out (held until mem_ack)
//   mem_ack/mem_rdata           memory completion and read data in
//   if_wait/ls_wait             stall flags to ctrl
//   bus_err                     one-cycle timeout pulse
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                if_wait,
    output logic                ls_wait,
    output logic                bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_LS
    } state_t;

    // Abort fires on the edge that would bring the count to TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tmo_cnt;
    logic       winner_ls;
    logic       idle;

    assign idle = (state == IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls;

    // On contention the side that did not own the last accept wins.
    always_comb begin
        winner_ls = ls_req & (~if_req | ~last_ls);
    end
`else
    always_comb begin
        winner_ls = ls_req;
    end
`endif

    assign ls_gnt  = idle & ls_req & winner_ls;
    assign if_gnt  = idle & if_req & ~winner_ls;
    assign if_wait = rst_n & if_req & ~if_gnt;
    assign ls_wait = rst_n & ls_req & ~ls_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            bus_err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls   <= 1'b0;
`endif
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_gnt) begin
                        state     <= BUSY_LS;
                        tmo_cnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= ls_we;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        mem_wstrb <= ls_wstrb;
`ifdef ARB_ROUND_ROBIN_EN
                        last_ls   <= 1'b1;
`endif
                    end else if (if_gnt) begin
                        state     <= BUSY_IF;
                        tmo_cnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_ls   <= 1'b0;
`endif
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    // An ack in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_we ? '0 : mem_rdata;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (state == BUSY_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the fetch path (ifu) and the load/store path (lsu).
- Serialises requests through a 3-state FSM and drives a req/ack handshake toward memory.
- Returns read data and completion pulses to the winning requester.
- Exports per-requester wait flags to ctrl so the pipeline stalls while a requester is not served.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte strobes.
- TIMEOUT, 255, max cycles mem_req may stay high without mem_ack before abort; range 1..255.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle fetch completion.
- if_rdata  out  DATA_W  fetched word, valid with if_rvalid.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store.
- ls_addr  in  ADDR_W  data address.
- ls_wdata  in  DATA_W  store data.
- ls_wstrb  in  DATA_W/8  store byte enables.
- ls_gnt  out  1  load/store accepted this cycle.
- ls_rvalid  out  1  one-cycle load/store completion.
- ls_rdata  out  DATA_W  load data, valid with ls_rvalid; 0 for stores.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- if_wait  out  1  if_req & ~if_gnt, to ctrl stall logic.
- ls_wait  out  1  ls_req & ~ls_gnt, to ctrl stall logic.
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE.
  - All registered outputs = 0: mem_*, *_rvalid, *_rdata, bus_err.
  - Timeout counter = 0.
  - Any in-flight transfer is abandoned with no rvalid.
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- Grants (combinational, IDLE only):
  - ls_gnt = ls_req & winner_ls.
  - if_gnt = if_req & ~winner_ls.
  - Both gnt = 0 outside IDLE.
  - Only one gnt is ever asserted per cycle.
- Accept at edge N (grant cycle):
  - Latch addr/we/wdata/wstrb. For ifu: we = 0, wstrb = all ones.
  - State goes to BUSY_IF or BUSY_LS.
  - mem_req = 1 from cycle N+1; mem_* stable until ack.
- Completion:
  - In BUSY_x, mem_ack sampled high at edge M: mem_req drops at M+1.
  - x_rvalid = 1 for exactly one cycle at M+1; x_rdata = mem_rdata registered (0 for stores).
  - State returns to IDLE at M+1, so a new grant is possible in cycle M+1.
  - Minimum transaction occupancy is 2 cycles.
- mem_ack outside BUSY is ignored.
- Timeout: counter increments each BUSY cycle without ack. On reaching TIMEOUT:
  - mem_req drops.
  - x_rvalid pulses with x_rdata = 0.
  - bus_err pulses.
  - State returns to IDLE.
  - mem_ack arriving in the same cycle as the timeout takes priority: normal completion, no bus_err.
- Counter clears on every accept.
- A requester dropping req while not granted is legal; it receives nothing.
- Wait flags are combinational from req and gnt and are 0 during reset.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a last_owner flip-flop (reset = ifu) records the owner of each accept. When both request in IDLE, the requester that did not own the previous accept wins. A single requester always wins.
- Undefined: fixed priority, winner_ls = ls_req. Loads/stores always beat fetch.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100 at cycle 0 → if_gnt=1 at cycle 0; mem_req=1, mem_addr=0x100, mem_we=0 at cycle 1. mem_ack with mem_rdata=0x00500093 at cycle 3 → if_rvalid=1, if_rdata=0x00500093 at cycle 4; mem_req=0.
- Store: ls_req=1, ls_we=1, ls_addr=0x2004, ls_wdata=0xDEADBEEF, ls_wstrb=0x3; ack after 1 cycle → mem_wstrb=0x3, mem_we=1; ls_rvalid pulse; ls_rdata=0.
- Contention, macro undefined: both req every cycle for 3 transactions → all three granted to lsu; if_wait=1 throughout. Macro defined: grant order ls, if, ls.
- Timeout: TIMEOUT=4, fetch, never ack → mem_req high 4 cycles, then if_rvalid=1, if_rdata=0, bus_err=1 for one cycle; state IDLE.
- Ack on timeout boundary: TIMEOUT=4, ack in the 4th BUSY cycle → normal data returned, bus_err=0.
- Reset mid-transfer: rst_n=0 while BUSY_LS with mem_req=1 → mem_req=0 immediately; no ls_rvalid after release; first grant after release is accepted normally.
